// File: rtl/ras_shadow_ctrl_if.sv
// Commit-side and shadow-stack-side signal bundle for ras_shadow_ctrl.
// The slave modport is the controller; the master modport is whatever
// drives commit events and models the attached shadow stack.
interface ras_shadow_ctrl_if #(
   parameter int DATA_W = 32
);
   logic              i_valid;
   logic [1:0]        i_type;
   logic [DATA_W-1:0] i_link;
   logic [DATA_W-1:0] i_target;
   logic              o_ready;
   logic              o_push;
   logic [DATA_W-1:0] o_push_data;
   logic              o_pop;
   logic              i_full;
   logic              i_empty;
   logic [DATA_W-1:0] i_top;
   logic              i_clear;
   logic              o_violation;
   logic [1:0]        o_cause;
   logic [DATA_W-1:0] o_bad_target;
   logic [DATA_W-1:0] o_expected;
   logic              o_overflow;

   modport slave (
      input  i_valid, i_type, i_link, i_target,
      output o_ready, o_push, o_push_data, o_pop,
      input  i_full, i_empty, i_top, i_clear,
      output o_violation, o_cause, o_bad_target, o_expected, o_overflow
   );

   modport master (
      output i_valid, i_type, i_link, i_target,
      input  o_ready, o_push, o_push_data, o_pop,
      output i_full, i_empty, i_top, i_clear,
      input  o_violation, o_cause, o_bad_target, o_expected, o_overflow
   );
endinterface

// File: rtl/ras_shadow_ctrl.sv
// Return-address shadow-stack controller.
// Commit events (CALL / RET / CORET) are staged for one cycle, then turned
// into push/pop strobes for an external shadow stack. RET targets are
// compared with the stack top; the first mismatch or underflow is latched
// as a sticky violation, and calls dropped on a full stack set a sticky
// overflow flag. i_clear wipes both.
// Optional build macro SHADOW_STACK_HALT_EN: when defined, commit is stalled
// (o_ready=0) while a violation is pending, until i_clear.
module ras_shadow_ctrl #(
   parameter int DATA_W  = 32,
   parameter int CMP_LSB = 1
) (
   input logic              clk,
   input logic              rst,
   ras_shadow_ctrl_if.slave bus
);

   localparam logic [1:0] T_CALL      = 2'b01;
   localparam logic [1:0] T_RET       = 2'b10;
   localparam logic [1:0] T_CORET     = 2'b11;
   localparam logic [1:0] C_MISMATCH  = 2'b01;
   localparam logic [1:0] C_UNDERFLOW = 2'b10;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      PUSH2 = 2'd1,
      ALARM = 2'd2
   } state_t;

   state_t            state_q;

   logic              stg_vld_q;
   logic [1:0]        stg_type_q;
   logic [DATA_W-1:0] stg_link_q;
   logic [DATA_W-1:0] stg_target_q;

   logic              viol_q,  viol_d;
   logic [1:0]        cause_q, cause_d;
   logic [DATA_W-1:0] bad_q,   bad_d;
   logic [DATA_W-1:0] exp_q,   exp_d;
   logic              ovf_q,   ovf_d;

   logic              in_push2;
   logic              ret_exec;
   logic              call_exec;
   logic              coret_half;
   logic              push_req;
   logic              ready;
   logic              accept;
   logic              new_viol;
   logic [1:0]        new_cause;

   // Addresses are equal once the CMP_LSB low bits are disregarded.
   function automatic logic addr_match(input logic [DATA_W-1:0] a,
                                       input logic [DATA_W-1:0] b);
      logic [DATA_W-1:0] diff;
      diff = (a ^ b) >> CMP_LSB;
      return (diff == '0);
   endfunction

   // The staged event can only be present outside PUSH2, because o_ready is
   // held low during the CORET pop half; the state test is kept for clarity.
   assign in_push2   = (state_q == PUSH2);
   assign ret_exec   = stg_vld_q && stg_type_q[1] && !in_push2;
   assign call_exec  = stg_vld_q && (stg_type_q == T_CALL) && !in_push2;
   assign coret_half = stg_vld_q && (stg_type_q == T_CORET) && !in_push2;
   assign push_req   = call_exec || in_push2;

`ifdef SHADOW_STACK_HALT_EN
   assign ready = !coret_half && (state_q != ALARM);
`else
   assign ready = !coret_half;
`endif

   assign accept = bus.i_valid && ready;

   // Full/empty are only consulted through push_req/ret_exec, i.e. in the
   // cycle the staged event (or the CORET push half) actually executes.
   assign bus.o_ready       = ready;
   assign bus.o_push        = push_req && !bus.i_full;
   assign bus.o_push_data   = stg_link_q;
   assign bus.o_pop         = ret_exec && !bus.i_empty;
   assign bus.o_violation   = viol_q;
   assign bus.o_cause       = cause_q;
   assign bus.o_bad_target  = bad_q;
   assign bus.o_expected    = exp_q;
   assign bus.o_overflow    = ovf_q;

   // Classify the executing return and work out the next sticky status.
   always_comb begin
      viol_d    = viol_q;
      cause_d   = cause_q;
      bad_d     = bad_q;
      exp_d     = exp_q;
      ovf_d     = ovf_q;
      new_viol  = 1'b0;
      new_cause = 2'b00;

      if (ret_exec) begin
         if (bus.i_empty) begin
            new_viol  = 1'b1;
            new_cause = C_UNDERFLOW;
         end else if (!addr_match(stg_target_q, bus.i_top)) begin
            new_viol  = 1'b1;
            new_cause = C_MISMATCH;
         end
      end

      // Clear wins over anything detected in the same cycle.
      if (bus.i_clear) begin
         viol_d  = 1'b0;
         cause_d = 2'b00;
         bad_d   = '0;
         exp_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         if (new_viol && !viol_q) begin
            viol_d  = 1'b1;
            cause_d = new_cause;
            bad_d   = stg_target_q;
            exp_d   = bus.i_empty ? '0 : bus.i_top;
         end
         if (push_req && bus.i_full) begin
            ovf_d = 1'b1;
         end
      end
   end

   // Control FSM plus registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         viol_q  <= 1'b0;
         cause_q <= 2'b00;
         bad_q   <= '0;
         exp_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         viol_q  <= viol_d;
         cause_q <= cause_d;
         bad_q   <= bad_d;
         exp_q   <= exp_d;
         ovf_q   <= ovf_d;
         case (state_q)
            RUN, ALARM: begin
               if (coret_half) begin
                  state_q <= PUSH2;
               end else if (viol_d) begin
                  state_q <= ALARM;
               end else begin
                  state_q <= RUN;
               end
            end
            PUSH2: begin
               state_q <= viol_d ? ALARM : RUN;
            end
            default: begin
               state_q <= RUN;
            end
         endcase
      end
   end

   // Stage occupancy; type 00 is accepted but never occupies the stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stg_vld_q <= 1'b0;
      end else begin
         stg_vld_q <= accept && (bus.i_type != 2'b00);
      end
   end

   // Stage payload; the link stays put through PUSH2 because o_ready is low
   // in the preceding pop-half cycle.
   always_ff @(posedge clk) begin
      if (accept) begin
         stg_type_q   <= bus.i_type;
         stg_link_q   <= bus.i_link;
         stg_target_q <= bus.i_target;
      end
   end

endmodule

// File: tb/tb_ras_shadow_ctrl.sv
// Bench for ras_shadow_ctrl: a small behavioural shadow stack answers the
// controller, a reference model predicts the stream of push/pop strobes
// and status rises, and a monitor compares them as they appear.
module tb_ras_shadow_ctrl;
   localparam int DW    = 32;
   localparam int CL    = 1;
   localparam int DEPTH = 4;

   localparam logic [1:0] CALL  = 2'b01;
   localparam logic [1:0] RET   = 2'b10;
   localparam logic [1:0] CORET = 2'b11;

   localparam int K_PUSH = 0;
   localparam int K_POP  = 1;
   localparam int K_VIOL = 2;
   localparam int K_OVF  = 3;

   typedef struct {
      int            kind;
      logic [DW-1:0] d0;
      logic [DW-1:0] d1;
      logic [1:0]    c;
   } tok_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ras_shadow_ctrl_if #(.DATA_W(DW)) bus ();

   ras_shadow_ctrl #(.DATA_W(DW), .CMP_LSB(CL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errs   = 0;
   int checks = 0;

   // ---------------- attached shadow stack ----------------
   logic [DW-1:0] mem [DEPTH];
   int            cnt      = 0;
   logic          push_pend = 1'b0;
   logic          pop_pend  = 1'b0;
   logic [DW-1:0] push_dat  = '0;

   assign bus.i_full  = (cnt == DEPTH);
   assign bus.i_empty = (cnt == 0);
   assign bus.i_top   = (cnt == 0) ? '0 : mem[(cnt == 0) ? 0 : cnt - 1];

   always @(negedge clk) begin
      push_pend = bus.o_push;
      pop_pend  = bus.o_pop;
      push_dat  = bus.o_push_data;
   end

   always @(posedge clk) begin
      if (push_pend && cnt < DEPTH) begin
         mem[cnt] <= push_dat;
         cnt      <= cnt + 1;
      end else if (pop_pend && cnt > 0) begin
         cnt <= cnt - 1;
      end
   end

   // ---------------- reference model ----------------
   tok_t          expq [$];
   logic [DW-1:0] mstk [$];
   logic          mviol = 1'b0;
   logic [1:0]    mcause = 2'b00;
   logic [DW-1:0] mbad = '0;
   logic [DW-1:0] mexp = '0;
   logic          movf = 1'b0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      checks++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic model_clear();
      mviol  = 1'b0;
      mcause = 2'b00;
      mbad   = '0;
      mexp   = '0;
      movf   = 1'b0;
   endtask

   task automatic model_call(input logic [DW-1:0] link);
      tok_t t;
      if (mstk.size() < DEPTH) begin
         mstk.push_back(link);
         t = '{K_PUSH, link, '0, 2'b00};
         expq.push_back(t);
      end else if (!movf) begin
         movf = 1'b1;
         t = '{K_OVF, '0, '0, 2'b00};
         expq.push_back(t);
      end
   endtask

   task automatic model_ret(input logic [DW-1:0] target, input bit clr);
      tok_t          t;
      bit            bad;
      logic [1:0]    c;
      logic [DW-1:0] e;
      bad = 0;
      c   = 2'b00;
      e   = '0;
      if (mstk.size() == 0) begin
         bad = 1;
         c   = 2'b10;
      end else begin
         e = mstk.pop_back();
         t = '{K_POP, e, '0, 2'b00};
         expq.push_back(t);
         if ((target / (1 << CL)) != (e / (1 << CL))) begin
            bad = 1;
            c   = 2'b01;
         end
      end
      if (clr) begin
         model_clear();
      end else if (bad && !mviol) begin
         mviol  = 1'b1;
         mcause = c;
         mbad   = target;
         mexp   = e;
         t = '{K_VIOL, target, e, c};
         expq.push_back(t);
      end
   endtask

   task automatic model_event(input logic [1:0] ty, input logic [DW-1:0] link,
                              input logic [DW-1:0] tgt, input bit clr);
      case (ty)
         CALL:    model_call(link);
         RET:     model_ret(tgt, clr);
         CORET: begin
            model_ret(tgt, clr);
            model_call(link);
         end
         default: ;
      endcase
   endtask

   // ---------------- monitor ----------------
   task automatic observe(input int kind, input logic [DW-1:0] d0,
                          input logic [DW-1:0] d1, input logic [1:0] c);
      tok_t t;
      if (expq.size() == 0) begin
         checks++;
         errs++;
         $display("FAIL unexpected_output: got kind %0d with nothing outstanding", kind);
      end else begin
         t = expq.pop_front();
         check("output_kind", kind, t.kind);
         if (kind == t.kind) begin
            if (kind == K_PUSH) check("push_data", d0, t.d0);
            if (kind == K_POP)  check("pop_top", d0, t.d0);
            if (kind == K_VIOL) begin
               check("viol_bad_target", d0, t.d0);
               check("viol_expected", d1, t.d1);
               check("viol_cause", c, t.c);
            end
         end
      end
   endtask

   logic prev_v = 1'b0;
   logic prev_o = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         prev_v = 1'b0;
         prev_o = 1'b0;
      end else begin
         if (bus.o_violation && !prev_v)
            observe(K_VIOL, bus.o_bad_target, bus.o_expected, bus.o_cause);
         if (bus.o_overflow && !prev_o)
            observe(K_OVF, '0, '0, 2'b00);
         if (bus.o_push || bus.o_pop)
            check("no_push_with_pop", bus.o_push & bus.o_pop, 0);
         if (bus.o_push)
            observe(K_PUSH, bus.o_push_data, '0, 2'b00);
         if (bus.o_pop)
            observe(K_POP, bus.i_top, '0, 2'b00);
         prev_v = bus.o_violation;
         prev_o = bus.o_overflow;
      end
   end

   // ---------------- driver ----------------
   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] ty, input logic [DW-1:0] link,
                       input logic [DW-1:0] tgt, input bit clr_exec);
      int w;
      w = 0;
      while (!bus.o_ready && w < 50) begin
         @(posedge clk);
         #1;
         w++;
      end
      if (!bus.o_ready) begin
         checks++;
         errs++;
         $display("FAIL ready_timeout: o_ready=%0b required 1", bus.o_ready);
         return;
      end
      bus.i_valid  = 1'b1;
      bus.i_type   = ty;
      bus.i_link   = link;
      bus.i_target = tgt;
      model_event(ty, link, tgt, clr_exec);
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      if (clr_exec) begin
         bus.i_clear = 1'b1;
         @(posedge clk);
         #1;
         bus.i_clear = 1'b0;
      end
   endtask

   task automatic quiesce_clear();
      settle(4);
      check("sticky_violation", bus.o_violation, mviol);
      check("sticky_cause", bus.o_cause, mcause);
      check("sticky_bad_target", bus.o_bad_target, mbad);
      check("sticky_expected", bus.o_expected, mexp);
      check("sticky_overflow", bus.o_overflow, movf);
      bus.i_clear = 1'b1;
      @(posedge clk);
      #1;
      bus.i_clear = 1'b0;
      model_clear();
      check("clear_violation", bus.o_violation, 0);
      check("clear_overflow", bus.o_overflow, 0);
      check("clear_ready", bus.o_ready, 1);
   endtask

   logic [1:0]    rty;
   logic [DW-1:0] rlink;
   logic [DW-1:0] rtgt;
   int            r;

   initial begin
      bus.i_valid  = 1'b0;
      bus.i_type   = 2'b00;
      bus.i_link   = '0;
      bus.i_target = '0;
      bus.i_clear  = 1'b0;
      rst = 1'b1;
      settle(2);
      check("rst_ready", bus.o_ready, 1);
      check("rst_push", bus.o_push, 0);
      check("rst_pop", bus.o_pop, 0);
      check("rst_violation", bus.o_violation, 0);
      check("rst_cause", bus.o_cause, 0);
      check("rst_bad_target", bus.o_bad_target, 0);
      check("rst_expected", bus.o_expected, 0);
      check("rst_overflow", bus.o_overflow, 0);
      rst = 1'b0;
      settle(1);
      check("release_push", bus.o_push, 0);
      check("release_pop", bus.o_pop, 0);

      // matched call/return
      send(CALL, 32'h1000, '0, 0);
      check("call_push", bus.o_push, 1);
      check("call_push_data", bus.o_push_data, 32'h1000);
      send(RET, '0, 32'h1000, 0);
      check("ret_pop", bus.o_pop, 1);
      settle(3);
      check("match_no_violation", bus.o_violation, 0);

      // mismatched return
      send(CALL, 32'h1000, '0, 0);
      send(RET, '0, 32'h2000, 0);
      check("mismatch_pop_anyway", bus.o_pop, 1);
      settle(3);
      check("mismatch_violation", bus.o_violation, 1);
      check("mismatch_cause", bus.o_cause, 2'b01);
      check("mismatch_bad_target", bus.o_bad_target, 32'h2000);
      check("mismatch_expected", bus.o_expected, 32'h1000);
`ifdef SHADOW_STACK_HALT_EN
      check("halt_ready_low", bus.o_ready, 0);
`else
      check("nohalt_ready_high", bus.o_ready, 1);
`endif
      quiesce_clear();

      // underflow
      send(RET, '0, 32'h40, 0);
      check("underflow_no_pop", bus.o_pop, 0);
      settle(3);
      check("underflow_violation", bus.o_violation, 1);
      check("underflow_cause", bus.o_cause, 2'b10);
      check("underflow_expected", bus.o_expected, 0);
      quiesce_clear();

      // overflow on a full stack
      for (int i = 1; i <= DEPTH; i++) send(CALL, DW'(i * 32'h100), '0, 0);
      send(CALL, 32'h500, '0, 0);
      check("full_no_push", bus.o_push, 0);
      settle(3);
      check("full_overflow", bus.o_overflow, 1);
      check("full_no_violation", bus.o_violation, 0);
      quiesce_clear();
      for (int i = 0; i < DEPTH; i++) send(RET, '0, mstk[mstk.size() - 1], 0);

      // co-routine swap
      send(CALL, 32'h500, '0, 0);
      send(CORET, 32'h3000, 32'h500, 0);
      check("coret_pop", bus.o_pop, 1);
      check("coret_pop_no_push", bus.o_push, 0);
      check("coret_pop_ready", bus.o_ready, 0);
      settle(1);
      check("coret_push", bus.o_push, 1);
      check("coret_push_data", bus.o_push_data, 32'h3000);
      check("coret_push_no_pop", bus.o_pop, 0);
      check("coret_push_ready", bus.o_ready, 1);
      send(RET, '0, 32'h3000, 0);

      // clear coinciding with a new violation
      send(RET, '0, 32'h40, 1);
      settle(3);
      check("clear_beats_violation", bus.o_violation, 0);

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 9);
         rty = (r < 4) ? CALL : (r < 7) ? RET : (r < 9) ? CORET : 2'b00;
         rlink = DW'($urandom_range(1, 255)) << 4;
         if (mstk.size() > 0 && $urandom_range(0, 3) != 0) begin
            rtgt = mstk[mstk.size() - 1];
            if ($urandom_range(0, 1) == 1) rtgt = rtgt ^ 32'h1;
         end else begin
            rtgt = DW'($urandom_range(1, 255)) << 4;
         end
         send(rty, rlink, rtgt, 0);
`ifdef SHADOW_STACK_HALT_EN
         if (mviol) quiesce_clear();
`endif
         if ($urandom_range(0, 24) == 0) quiesce_clear();
         if ($urandom_range(0, 7) == 0) settle(1);
      end
      settle(6);
      check("all_outputs_seen", expq.size(), 0);
      quiesce_clear();

      // reset during the CORET push half
      send(CALL, 32'h700, '0, 0);
      send(CORET, 32'h3000, 32'h700, 0);
      settle(1);
      rst = 1'b1;
      #1;
      expq.delete();
      check("midrst_push", bus.o_push, 0);
      check("midrst_pop", bus.o_pop, 0);
      check("midrst_ready", bus.o_ready, 1);
      check("midrst_violation", bus.o_violation, 0);
      check("midrst_cause", bus.o_cause, 0);
      check("midrst_bad_target", bus.o_bad_target, 0);
      check("midrst_expected", bus.o_expected, 0);
      check("midrst_overflow", bus.o_overflow, 0);
      settle(1);
      rst = 1'b0;
      settle(1);
      check("midrst_release_push", bus.o_push, 0);
      check("midrst_release_pop", bus.o_pop, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/ras_shadow_ctrl.md
RAS_SHADOW_CTRL -- requirements
Module: ras_shadow_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32: address width, equal to the attached shadow stack's DATA_W.
REQ-002 SHALL have parameter CMP_LSB, default 1: number of low address bits ignored in the return compare.
REQ-003 SHALL have one clock and an asynchronous, active-high reset; both are fixed.
REQ-004 SHALL provide these ports, as name, direction, width and meaning:
- clk, in, 1: clock.
- rst, in, 1: async active-high reset.
- i_valid, in, 1: commit event valid.
- i_type, in, 2: 01 CALL, 10 RET, 11 CORET (pop then push), 00 ignored.
- i_link, in, DATA_W: return address to save (CALL/CORET).
- i_target, in, DATA_W: actual return target (RET/CORET).
- o_ready, out, 1: event accept.
- o_push, out, 1: stack push.
- o_push_data, out, DATA_W: stack write data.
- o_pop, out, 1: stack pop.
- i_full, in, 1: stack full.
- i_empty, in, 1: stack empty.
- i_top, in, DATA_W: stack top data, combinational.
- i_clear, in, 1: clear violation/overflow status.
- o_violation, out, 1: sticky violation.
- o_cause, out, 2: 01 MISMATCH, 10 UNDERFLOW.
- o_bad_target, out, DATA_W: offending target.
- o_expected, out, DATA_W: stack top at violation.
- o_overflow, out, 1: sticky, call dropped on full.

Function
REQ-005 SHALL accept an event when i_valid and o_ready are both 1; an event with type 00 is accepted and discarded.
REQ-006 SHALL register an accepted event into a one-entry stage (valid, type, link, target) at the accepting edge N.
REQ-007 SHALL, in cycle N+1 for a staged CALL, drive o_push=1 and o_push_data=link when i_full=0; when i_full=1 it SHALL drive no push and set o_overflow at edge N+2.
REQ-008 SHALL, in cycle N+1 for a staged RET with i_empty=0, drive o_pop=1 and compare target[DATA_W-1:CMP_LSB] with i_top[DATA_W-1:CMP_LSB].
- On inequality it SHALL latch violation=1, cause=MISMATCH, bad_target and expected at edge N+2.
- The pop SHALL occur even on a mismatch.
REQ-009 SHALL, for a staged RET with i_empty=1, drive no pop and latch violation=1, cause=UNDERFLOW, bad_target=target and expected=0.
REQ-010 SHALL handle a staged CORET in two cycles: the RET half in cycle N+1 (state RUN), then the CALL half from the held link in cycle N+2 (state PUSH2).
REQ-011 SHALL never assert o_push and o_pop in the same cycle.
REQ-012 SHALL implement FSM states RUN, PUSH2 and ALARM.
- RUN->PUSH2 when a staged CORET executes its pop half.
- PUSH2->RUN after one cycle.
- RUN->ALARM when a violation is latched.
- ALARM->RUN on i_clear.
REQ-013 SHALL drive o_ready=0 during the CORET pop-half cycle and 1 otherwise in RUN/PUSH2; ALARM behaviour is set by REQ-020/021.
REQ-014 SHALL record only the first violation; later violations SHALL NOT overwrite cause, bad_target or expected until i_clear.
REQ-015 SHALL give i_clear priority over a simultaneous new violation in the same cycle: status clears and the new violation is dropped.
REQ-016 SHALL not act on i_full/i_empty outside the cycle in which the staged event executes.

Reset
REQ-017 SHALL, on rst, immediately force the stage empty, the state to RUN, and o_push=0, o_pop=0, o_violation=0, o_cause=00, o_bad_target=0, o_expected=0, o_overflow=0 and o_ready=1.
REQ-018 SHALL drop any event in flight, including a pending CORET push half, when rst asserts mid-operation.
REQ-019 SHALL release reset without pushing or popping in the first cycle after deassertion.

Configuration
REQ-020 SHALL, when macro SHADOW_STACK_HALT_EN is defined, drive o_ready=0 in ALARM so that commit stalls until i_clear; the staged event at violation time SHALL still complete.
REQ-021 SHALL, without SHADOW_STACK_HALT_EN, keep o_ready per REQ-013 in ALARM and continue processing events, with status held sticky.

Verification
REQ-022 SHALL verify CALL link=0x1000 then RET target=0x1000 -> push at N+1, pop at N'+1, o_violation stays 0.
REQ-023 SHALL verify CALL 0x1000 then RET 0x2000 -> o_violation=1, o_cause=01, o_bad_target=0x2000, o_expected=0x1000; with HALT_EN o_ready=0 until i_clear.
REQ-024 SHALL verify RET 0x40 with i_empty=1 -> no o_pop, o_cause=10, o_expected=0.
REQ-025 SHALL verify CALL with i_full=1 -> no o_push, o_overflow=1, o_violation=0; i_clear returns o_overflow to 0.
REQ-026 SHALL verify CORET target=top and link=0x3000 -> o_pop cycle N+1, o_push=0x3000 cycle N+2, o_ready=0 only in N+1, never push and pop together.
REQ-027 SHALL verify rst asserted in the CORET PUSH2 cycle -> no push that cycle and all outputs at their reset values.
